// File: rtl/des_pkg.sv
// Purpose : shared DES key-schedule tables, rotation schedules, FSM state and helper functions.
// Latency : n/a (package of constants and combinational helpers).
// Backpressure : n/a.
// Contents: PC-1 / PC-2 tables (DES 1-based bit numbers), encrypt/decrypt rotation schedules,
//           state_t enum, pc1() and rot_half() helpers, width localparams.
package des_pkg;

   localparam int HALF_W   = 28;
   localparam int SUBKEY_W = 48;
   localparam int CD_W     = 56;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Table entries are DES bit numbers: bit 1 is the MSB of the source vector.
   localparam int PC1_TABLE [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TABLE [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   // Left-rotate amounts per emission round when encrypting.
   localparam logic [1:0] ENC_ROT [16] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   // Right-rotate amounts per emission round when decrypting. Round 0 needs no
   // rotation because the 16 encrypt shifts sum to 28, so C16/D16 equal C0/D0.
   localparam logic [1:0] DEC_ROT [16] = '{
      2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   // PC-1: 64-bit key (DES bit 1 = key[63]) to 56-bit C||D (DES bit 1 = result[55]).
   function automatic logic [CD_W-1:0] pc1(input logic [63:0] key);
      logic [CD_W-1:0] r;
      r = '0;
      for (int i = 0; i < CD_W; i++) begin
         r[6'(CD_W - 1 - i)] = key[6'(64 - PC1_TABLE[i])];
      end
      return r;
   endfunction

   // Rotate one 28-bit half by 0..2 positions, left or right.
   function automatic logic [HALF_W-1:0] rot_half(input logic [HALF_W-1:0] x,
                                                  input logic [1:0]        amt,
                                                  input logic              right);
      logic [HALF_W-1:0] r;
      r = x;
      case (amt)
         2'd1:    r = right ? {x[0],    x[27:1]} : {x[26:0], x[27]};
         2'd2:    r = right ? {x[1:0],  x[27:2]} : {x[25:0], x[27:26]};
         default: r = x;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/des_pc2.sv
// Purpose : combinational PC-2 permutation, 56-bit C||D to 48-bit round subkey.
// Latency : 0 cycles (pure combinational).
// Backpressure : none; no handshake.
// Ports: cd_i [55:0] C||D (DES bit 1 = cd_i[55]); subkey_o [47:0] (DES bit 1 = subkey_o[47]).
module des_pc2
   import des_pkg::*;
(
   input  logic [CD_W-1:0]     cd_i,
   output logic [SUBKEY_W-1:0] subkey_o
);

   always_comb begin
      subkey_o = '0;
      for (int j = 0; j < SUBKEY_W; j++) begin
         subkey_o[6'(SUBKEY_W - 1 - j)] = cd_i[6'(CD_W - PC2_TABLE[j])];
      end
   end

endmodule

// File: rtl/des_key_schedule.sv
// Purpose : sequential DES round-key generator; accepts one key, emits K1..K16 (or K16..K1).
// Latency : first subkey valid 1 cycle after key accept; one subkey per handshake; 17-cycle key period.
// Backpressure : subkey/round_idx/last hold while subkey_ready=0; key_ready=0 for the whole sequence.
// Ports: clk, rst_n (async active-low); key_valid/key_ready/key/decrypt (key side);
//        subkey_valid/subkey_ready/subkey/round_idx/last (subkey side); parity_err (advisory).
// Option macro DES_KEY_PARITY_CHECK_EN: enables the per-byte odd-parity check driving parity_err;
//        when undefined parity_err is tied 0.
module des_key_schedule
   import des_pkg::*;
#(
   parameter int KEY_WIDTH    = 64,
   parameter int SUBKEY_WIDTH = 48
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    key_valid,
   input  logic [KEY_WIDTH-1:0]    key,
   input  logic                    decrypt,
   output logic                    key_ready,
   output logic                    subkey_valid,
   input  logic                    subkey_ready,
   output logic [SUBKEY_WIDTH-1:0] subkey,
   output logic [3:0]              round_idx,
   output logic                    last,
   output logic                    parity_err
);

   state_t                state_q, state_d;
   logic [HALF_W-1:0]     c_q, c_d;
   logic [HALF_W-1:0]     d_q, d_d;
   logic [SUBKEY_W-1:0]   subkey_q, subkey_d;
   logic [3:0]            round_q, round_d;
   logic                  dec_q, dec_d;
   logic                  last_q, last_d;

   logic                  accept;
   logic                  load_sub;
   logic [CD_W-1:0]       cd_key;
   logic [3:0]            round_nxt;
   logic [1:0]            rot_amt;
   logic [SUBKEY_W-1:0]   pc2_out;

   assign accept = (state_q == IDLE) && key_valid;

   always_comb begin
      state_d   = state_q;
      c_d       = c_q;
      d_d       = d_q;
      round_d   = round_q;
      dec_d     = dec_q;
      last_d    = last_q;
      load_sub  = 1'b0;
      cd_key    = pc1(key);
      round_nxt = round_q + 4'd1;
      rot_amt   = 2'd0;

      unique case (state_q)
         IDLE: begin
            if (key_valid) begin
               // Pre-rotate by the round-0 amount so the first subkey is ready next cycle.
               rot_amt  = decrypt ? DEC_ROT[0] : ENC_ROT[0];
               c_d      = rot_half(cd_key[55:28], rot_amt, decrypt);
               d_d      = rot_half(cd_key[27:0],  rot_amt, decrypt);
               dec_d    = decrypt;
               round_d  = 4'd0;
               last_d   = 1'b0;
               load_sub = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (subkey_ready) begin
               if (round_q == 4'd15) begin
                  last_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  rot_amt  = dec_q ? DEC_ROT[round_nxt] : ENC_ROT[round_nxt];
                  c_d      = rot_half(c_q, rot_amt, dec_q);
                  d_d      = rot_half(d_q, rot_amt, dec_q);
                  round_d  = round_nxt;
                  last_d   = (round_nxt == 4'd15);
                  load_sub = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Single PC-2 instance on the next-C/D value, so the subkey register updates
   // in the same edge as the C/D registers.
   des_pc2 u_pc2 (
      .cd_i     ({c_d, d_d}),
      .subkey_o (pc2_out)
   );

   assign subkey_d = load_sub ? pc2_out : subkey_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         c_q      <= '0;
         d_q      <= '0;
         subkey_q <= '0;
         round_q  <= '0;
         dec_q    <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         c_q      <= c_d;
         d_q      <= d_d;
         subkey_q <= subkey_d;
         round_q  <= round_d;
         dec_q    <= dec_d;
         last_q   <= last_d;
      end
   end

`ifdef DES_KEY_PARITY_CHECK_EN
   logic parity_err_q, parity_err_d;
   logic key_bad;

   // DES keys carry odd parity per byte; an even byte marks a corrupted key.
   always_comb begin
      key_bad = 1'b0;
      for (int b = 0; b < 8; b++) begin
         if (!(^key[8*b +: 8])) key_bad = 1'b1;
      end
      parity_err_d = accept ? key_bad : parity_err_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_err_q <= 1'b0;
      else        parity_err_q <= parity_err_d;
   end

   assign parity_err = parity_err_q;
`else
   // Parity bits are dropped by PC-1 and nothing else looks at them here.
   logic unused_parity_bits;
   assign unused_parity_bits = ^{key[56], key[48], key[40], key[32],
                                 key[24], key[16], key[8],  key[0]};
   assign parity_err = 1'b0;
`endif

   assign key_ready    = (state_q == IDLE);
   assign subkey_valid = (state_q == RUN);
   assign subkey       = subkey_q;
   assign round_idx    = round_q;
   assign last         = last_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Purpose : self-checking bench for des_key_schedule against a cumulative-shift DES key-schedule model.
// Latency : checks 1-cycle accept-to-round-0 and the 17-cycle key-to-key period.
// Backpressure : exercises stalls on subkey_ready, ignored key_valid during a sequence, reset mid-run.
module tb_des_key_schedule;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        key_valid;
   logic [63:0] key;
   logic        decrypt;
   logic        key_ready;
   logic        subkey_valid;
   logic        subkey_ready;
   logic [47:0] subkey;
   logic [3:0]  round_idx;
   logic        last;
   logic        parity_err;

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;

   localparam int M_PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int M_PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int M_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   logic [47:0] exp_ks [16];
   logic [47:0] got_ks [16];
   logic [47:0] enc_got [16];

   always #5 clk = ~clk;

   des_key_schedule dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_valid    (key_valid),
      .key          (key),
      .decrypt      (decrypt),
      .key_ready    (key_ready),
      .subkey_valid (subkey_valid),
      .subkey_ready (subkey_ready),
      .subkey       (subkey),
      .round_idx    (round_idx),
      .last         (last),
      .parity_err   (parity_err)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Key schedule from first principles: Cn/Dn are C0/D0 left-rotated by the
   // running total of shifts; decrypt order is the encrypt list reversed.
   task automatic build_model(input logic [63:0] k, input bit dec);
      logic [27:0] c0, d0, c, d;
      logic [55:0] cc, dd, cd;
      logic [47:0] ks;
      logic [47:0] enc [16];
      int          total;
      c0 = '0;
      d0 = '0;
      for (int i = 0; i < 28; i++) begin
         c0[5'(27 - i)] = k[6'(64 - M_PC1[i])];
         d0[5'(27 - i)] = k[6'(64 - M_PC1[i + 28])];
      end
      total = 0;
      for (int r = 0; r < 16; r++) begin
         total = total + M_SHIFT[r];
         cc = {c0, c0} << total;
         dd = {d0, d0} << total;
         c  = cc[55:28];
         d  = dd[55:28];
         cd = {c, d};
         ks = '0;
         for (int j = 0; j < 48; j++) ks[6'(47 - j)] = cd[6'(56 - M_PC2[j])];
         enc[r] = ks;
      end
      for (int r = 0; r < 16; r++) exp_ks[r] = dec ? enc[15 - r] : enc[r];
   endtask

   function automatic logic exp_parity(input logic [63:0] k);
      logic bad;
      bad = 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
      for (int b = 0; b < 8; b++) if ((^k[8*b +: 8]) == 1'b0) bad = 1'b1;
`endif
      return bad;
   endfunction

   task automatic wait_ready();
      int t;
      t = 0;
      while (!key_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (!key_ready) check_eq("ready_timeout", 64'(key_ready), 64'd1);
   endtask

   // One full key sequence; stall_len cycles of backpressure at stall_round,
   // optional random stalls elsewhere. key_valid is pulsed with junk during stalls.
   task automatic run_key(input logic [63:0] k, input bit dec, input bit rnd_stall,
                          input int stall_round, input int stall_len);
      int n;
      build_model(k, dec);
      wait_ready();
      key          = k;
      decrypt      = dec;
      key_valid    = 1'b1;
      subkey_ready = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      decrypt   = ~dec;
      for (int r = 0; r < 16; r++) begin
         check_eq("valid", 64'(subkey_valid), 64'd1);
         check_eq("round", 64'(round_idx), 64'(r));
         check_eq("subkey", 64'(subkey), 64'(exp_ks[r]));
         check_eq("last", 64'(last), 64'(r == 15));
         check_eq("kready_run", 64'(key_ready), 64'd0);
         got_ks[r] = subkey;
         if (r == stall_round) n = stall_len;
         else if (rnd_stall && $urandom_range(0, 3) == 0) n = int'($urandom_range(1, 3));
         else n = 0;
         if (n > 0) begin
            subkey_ready = 1'b0;
            for (int s = 0; s < n; s++) begin
               key_valid = 1'b1;
               key       = {$urandom, $urandom};
               @(posedge clk); #1;
               check_eq("hold_subkey", 64'(subkey), 64'(exp_ks[r]));
               check_eq("hold_round", 64'(round_idx), 64'(r));
               check_eq("hold_last", 64'(last), 64'(r == 15));
            end
            key_valid    = 1'b0;
            subkey_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      check_eq("kready_done", 64'(key_ready), 64'd1);
      check_eq("valid_done", 64'(subkey_valid), 64'd0);
      check_eq("last_done", 64'(last), 64'd0);
      check_eq("parity", 64'(parity_err), 64'(exp_parity(k)));
   endtask

   initial begin
      logic [63:0] k2;
      int          c;
      logic        prev;
      logic        found;

      rst_n        = 1'b0;
      key_valid    = 1'b0;
      key          = '0;
      decrypt      = 1'b0;
      subkey_ready = 1'b0;
      #12;
      check_eq("rst_kready", 64'(key_ready), 64'd1);
      check_eq("rst_valid", 64'(subkey_valid), 64'd0);
      check_eq("rst_subkey", 64'(subkey), 64'd0);
      check_eq("rst_round", 64'(round_idx), 64'd0);
      check_eq("rst_last", 64'(last), 64'd0);
      check_eq("rst_parity", 64'(parity_err), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Known-answer encrypt and decrypt.
      run_key(KEY_STD, 1'b0, 1'b0, -1, 0);
      check_eq("enc_k1", 64'(got_ks[0]), 64'h1B02EFFC7072);
      check_eq("enc_k16", 64'(got_ks[15]), 64'hCB3D8B0E17F5);
      for (int r = 0; r < 16; r++) enc_got[r] = got_ks[r];
      run_key(KEY_STD, 1'b1, 1'b0, -1, 0);
      check_eq("dec_k1", 64'(got_ks[0]), 64'hCB3D8B0E17F5);
      check_eq("dec_k16", 64'(got_ks[15]), 64'h1B02EFFC7072);
      for (int r = 0; r < 16; r++) check_eq("dec_reverse", 64'(got_ks[r]), 64'(enc_got[15 - r]));

      // Backpressure at round 3 for 5 cycles.
      run_key(KEY_STD, 1'b0, 1'b0, 3, 5);

      // Parity: bad key then good key.
      run_key(KEY_BAD, 1'b0, 1'b0, -1, 0);
      @(posedge clk); #1;
      check_eq("parity_hold", 64'(parity_err), 64'(exp_parity(KEY_BAD)));
      run_key(KEY_STD, 1'b1, 1'b0, -1, 0);

      // Reset during round 7.
      build_model(KEY_STD, 1'b0);
      wait_ready();
      key          = KEY_STD;
      decrypt      = 1'b0;
      key_valid    = 1'b1;
      subkey_ready = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      for (int s = 0; s < 7; s++) begin
         @(posedge clk); #1;
      end
      check_eq("pre_rst_round", 64'(round_idx), 64'd7);
      check_eq("pre_rst_subkey", 64'(subkey), 64'(exp_ks[7]));
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", 64'(subkey_valid), 64'd0);
      check_eq("mid_rst_kready", 64'(key_ready), 64'd1);
      check_eq("mid_rst_subkey", 64'(subkey), 64'd0);
      check_eq("mid_rst_round", 64'(round_idx), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("post_rst_valid", 64'(subkey_valid), 64'd0);
      run_key({$urandom, $urandom}, 1'b0, 1'b0, -1, 0);

      // Back-to-back keys with key_valid held high.
      build_model(KEY_STD, 1'b0);
      wait_ready();
      key          = KEY_STD;
      decrypt      = 1'b0;
      key_valid    = 1'b1;
      subkey_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("b2b_first", 64'(subkey), 64'(exp_ks[0]));
      k2  = {$urandom, $urandom};
      key = k2;
      build_model(k2, 1'b0);
      c     = 0;
      prev  = key_ready;
      found = 1'b0;
      while (!found && c < 40) begin
         @(posedge clk); #1;
         c++;
         if (prev && subkey_valid) found = 1'b1;
         else prev = key_ready;
      end
      key_valid = 1'b0;
      check_eq("b2b_period", 64'(c), 64'd17);
      check_eq("b2b_second", 64'(subkey), 64'(exp_ks[0]));
      wait_ready();

      // Randomized keys, directions and stalls.
      for (int t = 0; t < 6; t++) begin
         run_key({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, -1, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
